// File: rtl/dom_conv_src.sv
// Source side of the domain-conversion interface: buffers tagged samples in a shared FIFO
// and emits them in order with frame sequencing, sample offsets and per-block pending status.
module dom_conv_src #(
  parameter int I_DATA_WIDTH   = 32,
  parameter int I_FDSSI_WIDTH  = 8,
  parameter int I_SSI_WIDTH    = 4,
  parameter int I_SAM_OFFSET   = 6,
  parameter int FIFO_NUM_O_BLK = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int BLK_W          = (FIFO_NUM_O_BLK > 1) ? $clog2(FIFO_NUM_O_BLK) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [I_DATA_WIDTH-1:0]   in_data,
  input  logic [BLK_W-1:0]          in_blk,
  input  logic                      in_last,
  input  logic [I_FDSSI_WIDTH-1:0]  in_fdssi,
  output logic                      valid_o,
  input  logic                      ready_o,
  output logic [I_DATA_WIDTH-1:0]   data_o,
  output logic                      wt_o,
  output logic [I_FDSSI_WIDTH-1:0]  FDSSI_o,
  output logic [I_SSI_WIDTH-1:0]    SSI_o,
  output logic [I_SAM_OFFSET-1:0]   s_o,
  output logic [FIFO_NUM_O_BLK-1:0] FDSTI_o_all,
  output logic                      err_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [I_DATA_WIDTH-1:0]  data;
    logic [BLK_W-1:0]         blk;
    logic                     last;
    logic [I_FDSSI_WIDTH-1:0] fdssi;
  } entry_t;

  entry_t                    mem_q [FIFO_DEPTH];
  entry_t                    head_s;
  entry_t                    wr_entry_s;
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             rd_ptr_q;
  logic [CW-1:0]             count_q;
  logic [CW-1:0]             count_d;
  logic [CW-1:0]             blk_cnt_q [FIFO_NUM_O_BLK];
  logic [CW-1:0]             blk_cnt_d [FIFO_NUM_O_BLK];
  logic [FIFO_NUM_O_BLK-1:0] fdsti_q;
  logic [FIFO_NUM_O_BLK-1:0] fdsti_d;
  logic [FIFO_NUM_O_BLK-1:0] inc_s;
  logic [FIFO_NUM_O_BLK-1:0] dec_s;
  logic                      valid_q;
  logic                      in_ready_q;
  logic                      err_q;
  logic [I_SSI_WIDTH-1:0]    ssi_q;
  logic [I_SAM_OFFSET-1:0]   s_q;
  logic                      push_s;
  logic                      blk_ok_s;
  logic                      wr_s;
  logic                      pop_s;

  // Handshake decode, occupancy and per-block pending-count next state
  always_comb begin
    push_s     = in_valid && in_ready_q;
    blk_ok_s   = (int'(in_blk) < FIFO_NUM_O_BLK);
    wr_s       = push_s && blk_ok_s;
    pop_s      = valid_q && ready_o;
    head_s     = mem_q[rd_ptr_q];
    wr_entry_s = {in_data, in_blk, in_last, in_fdssi};
    inc_s      = '0;
    dec_s      = '0;
    fdsti_d    = '0;
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    for (int b = 0; b < FIFO_NUM_O_BLK; b++) begin
      inc_s[b] = wr_s && (int'(in_blk) == b);
      dec_s[b] = pop_s && (int'(head_s.blk) == b);
      if (inc_s[b] && !dec_s[b]) begin
        blk_cnt_d[b] = blk_cnt_q[b] + CW'(1);
      end else if (dec_s[b] && !inc_s[b]) begin
        blk_cnt_d[b] = blk_cnt_q[b] - CW'(1);
      end else begin
        blk_cnt_d[b] = blk_cnt_q[b];
      end
      fdsti_d[b] = (blk_cnt_d[b] != '0);
    end
  end

  // FIFO storage, pointers, frame sequencing and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      for (int b = 0; b < FIFO_NUM_O_BLK; b++) begin
        blk_cnt_q[b] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fdsti_q    <= '0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
      ssi_q      <= '0;
      s_q        <= '0;
    end else begin
      if (wr_s) begin
        mem_q[wr_ptr_q] <= wr_entry_s;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      // The offset counter restarts on the last sample of a frame
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        if (head_s.last) begin
          s_q   <= '0;
          ssi_q <= ssi_q + I_SSI_WIDTH'(1);
        end else begin
          s_q   <= s_q + I_SAM_OFFSET'(1);
        end
      end
      if (push_s && !blk_ok_s) begin
        err_q <= 1'b1;
      end
      for (int b = 0; b < FIFO_NUM_O_BLK; b++) begin
        blk_cnt_q[b] <= blk_cnt_d[b];
      end
      count_q    <= count_d;
      fdsti_q    <= fdsti_d;
      valid_q    <= (count_d != '0);
      in_ready_q <= (count_d != FULL_CNT);
    end
  end

  assign in_ready    = in_ready_q;
  assign valid_o     = valid_q;
  assign data_o      = head_s.data;
  assign wt_o        = head_s.last;
  assign FDSSI_o     = head_s.fdssi;
  assign SSI_o       = ssi_q;
  assign s_o         = s_q;
  assign FDSTI_o_all = fdsti_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dom_conv_src.sv
// Self-checking bench for dom_conv_src: scoreboard monitor on the default instance plus
// directed scenario tasks; a second instance with three blocks covers out-of-range tags.
module tb_dom_conv_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_last, ready_o, valid_o, wt_o, err_o;
  logic [31:0] in_data, data_o;
  logic [1:0]  in_blk;
  logic [7:0]  in_fdssi, FDSSI_o;
  logic [3:0]  SSI_o;
  logic [5:0]  s_o;
  logic [3:0]  FDSTI_o_all;

  logic        b_in_valid, b_in_ready, b_in_last, b_ready_o, b_valid_o, b_wt_o, b_err_o;
  logic [31:0] b_in_data, b_data_o;
  logic [1:0]  b_in_blk;
  logic [7:0]  b_in_fdssi, b_FDSSI_o;
  logic [3:0]  b_SSI_o;
  logic [5:0]  b_s_o;
  logic [2:0]  b_FDSTI_o_all;

  dom_conv_src u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_blk(in_blk), .in_last(in_last), .in_fdssi(in_fdssi), .valid_o(valid_o),
    .ready_o(ready_o), .data_o(data_o), .wt_o(wt_o), .FDSSI_o(FDSSI_o), .SSI_o(SSI_o),
    .s_o(s_o), .FDSTI_o_all(FDSTI_o_all), .err_o(err_o)
  );

  dom_conv_src #(.FIFO_NUM_O_BLK(3)) u_bad (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_blk(b_in_blk), .in_last(b_in_last), .in_fdssi(b_in_fdssi), .valid_o(b_valid_o),
    .ready_o(b_ready_o), .data_o(b_data_o), .wt_o(b_wt_o), .FDSSI_o(b_FDSSI_o), .SSI_o(b_SSI_o),
    .s_o(b_s_o), .FDSTI_o_all(b_FDSTI_o_all), .err_o(b_err_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  fdssi;
    logic [5:0]  s;
    logic [3:0]  ssi;
    int          blk;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         tests = 0;
  int         fails = 0;
  bit         mon_en = 1'b0;
  int         m_cnt[4];
  logic [5:0] m_s;
  logic [3:0] m_ssi;
  logic [3:0] mon_ef;

  // Scoreboard monitor: model pushes at handshake, compares head on every pop
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      sb.delete();
      m_s   = 6'd0;
      m_ssi = 4'd0;
      for (int b = 0; b < 4; b++) m_cnt[b] = 0;
    end else begin
      for (int b = 0; b < 4; b++) mon_ef[b] = (m_cnt[b] != 0);
      tests++;
      if (FDSTI_o_all !== mon_ef) begin
        fails++;
        $display("FAIL mon_fdsti: got %b want %b at %0t", FDSTI_o_all, mon_ef, $time);
      end
      tests++;
      if (valid_o !== (sb.size() != 0)) begin
        fails++;
        $display("FAIL mon_valid: got %b want %b at %0t", valid_o, (sb.size() != 0), $time);
      end
      if (valid_o && ready_o && sb.size() != 0) begin
        mon_e = sb.pop_front();
        m_cnt[mon_e.blk]--;
        tests++;
        if ({data_o, wt_o, FDSSI_o, s_o, SSI_o} !==
            {mon_e.data, mon_e.last, mon_e.fdssi, mon_e.s, mon_e.ssi}) begin
          fails++;
          $display("FAIL mon_pop: got d=%h wt=%b f=%h s=%0d ssi=%0d want d=%h wt=%b f=%h s=%0d ssi=%0d",
                   data_o, wt_o, FDSSI_o, s_o, SSI_o,
                   mon_e.data, mon_e.last, mon_e.fdssi, mon_e.s, mon_e.ssi);
        end
      end
      if (in_valid && in_ready) begin
        mon_e.data  = in_data;
        mon_e.last  = in_last;
        mon_e.fdssi = in_fdssi;
        mon_e.s     = m_s;
        mon_e.ssi   = m_ssi;
        mon_e.blk   = int'(in_blk);
        sb.push_back(mon_e);
        m_cnt[mon_e.blk]++;
        if (in_last) begin
          m_s   = 6'd0;
          m_ssi = m_ssi + 4'd1;
        end else begin
          m_s   = m_s + 6'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input int blk,
                        input logic last, input logic [7:0] f);
    in_valid = v;
    in_data  = d;
    in_blk   = 2'(blk);
    in_last  = last;
    in_fdssi = f;
  endtask

  task automatic wait_empty(output bit ok);
    in_valid = 1'b0;
    ready_o  = 1'b1;
    for (int i = 0; i < 40 && valid_o; i++) tick();
    ok = !valid_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready_o = 1'b0;
    set_in(1'b0, 32'd0, 0, 1'b0, 8'd0);
    repeat (2) tick();
    tests++;
    if (valid_o !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: valid=%b in_ready=%b want 0 0", valid_o, in_ready);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tests++;
    if ({valid_o, SSI_o, s_o, FDSTI_o_all, err_o} !== 16'd0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b ssi=%0d s=%0d fdsti=%b err=%b want all 0",
               valid_o, SSI_o, s_o, FDSTI_o_all, err_o);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_frame();
    bit ok;
    ready_o = 1'b1;
    set_in(1'b1, 32'hA0, 2, 1'b0, 8'h10);
    tick();
    tests++;
    if (valid_o !== 1'b1 || FDSTI_o_all[2] !== 1'b1) begin
      fails++;
      $display("FAIL sf_latency: valid=%b fdsti2=%b want 1 1", valid_o, FDSTI_o_all[2]);
    end
    set_in(1'b1, 32'hA1, 2, 1'b0, 8'h11);
    tick();
    set_in(1'b1, 32'hA2, 2, 1'b1, 8'h12);
    tick();
    wait_empty(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL sf_drain: valid still %b want 0", valid_o);
    end
    tests++;
    if (SSI_o !== 4'd1 || s_o !== 6'd0 || FDSTI_o_all !== 4'b0000) begin
      fails++;
      $display("FAIL sf_after: ssi=%0d s=%0d fdsti=%b want 1 0 0000", SSI_o, s_o, FDSTI_o_all);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    bit acc;
    bit ok;
    idx = 0;
    ready_o = 1'b0;
    for (int c = 0; c < 12; c++) begin
      set_in(1'b1, 32'hB0 + idx, idx % 4, (idx == 4), 8'(idx));
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    tests++;
    if (idx !== 8 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_full: accepted=%0d in_ready=%b want 8 0", idx, in_ready);
    end
    repeat (3) tick();
    tests++;
    if ({valid_o, data_o, wt_o, s_o, SSI_o} !== {1'b1, 32'hB0, 1'b0, 6'd0, 4'd1}) begin
      fails++;
      $display("FAIL bp_hold: valid=%b data=%h wt=%b s=%0d ssi=%0d want 1 b0 0 0 1",
               valid_o, data_o, wt_o, s_o, SSI_o);
    end
    ready_o = 1'b1;
    tick();
    ready_o = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || data_o !== 32'hB1 || s_o !== 6'd1) begin
      fails++;
      $display("FAIL bp_release: in_ready=%b data=%h s=%0d want 1 b1 1", in_ready, data_o, s_o);
    end
    ready_o = 1'b1;
    for (int c = 0; c < 20 && idx < 10; c++) begin
      set_in(1'b1, 32'hB0 + idx, idx % 4, (idx == 4), 8'(idx));
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    wait_empty(ok);
    tests++;
    if (!ok || idx !== 10) begin
      fails++;
      $display("FAIL bp_drain: empty=%b accepted=%0d want 1 10", ok, idx);
    end
  endtask

  task automatic test_concurrent();
    bit ok;
    ready_o = 1'b0;
    set_in(1'b1, 32'hD0, 0, 1'b0, 8'h20);
    tick();
    set_in(1'b1, 32'hD1, 1, 1'b0, 8'h21);
    tick();
    ready_o = 1'b1;
    for (int i = 2; i < 22; i++) begin
      set_in(1'b1, 32'hD0 + i, i % 2, (i % 4 == 3), 8'(8'h20 + i));
      tick();
      tests++;
      if (FDSTI_o_all[1:0] !== 2'b11 || valid_o !== 1'b1 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL cc_steady: fdsti=%b valid=%b in_ready=%b want 11 1 1",
                 FDSTI_o_all[1:0], valid_o, in_ready);
      end
    end
    wait_empty(ok);
    tests++;
    if (!ok || SSI_o !== 4'd7) begin
      fails++;
      $display("FAIL cc_drain: empty=%b ssi=%0d want 1 7", ok, SSI_o);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    bit saw;
    logic [3:0] prev_ssi;
    logic [5:0] prev_s;
    ready_o  = 1'b1;
    saw      = 1'b0;
    prev_ssi = 4'd7;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) set_in(1'b1, 32'hC00 + i, 3, 1'b1, 8'(i));
      else        in_valid = 1'b0;
      tick();
      if (prev_ssi == 4'd15 && SSI_o == 4'd0) saw = 1'b1;
      prev_ssi = SSI_o;
    end
    tests++;
    if (!saw || SSI_o !== 4'd7) begin
      fails++;
      $display("FAIL wrap_ssi: saw15to0=%b ssi=%0d want 1 7", saw, SSI_o);
    end
    saw    = 1'b0;
    prev_s = 6'd0;
    for (int i = 0; i < 65; i++) begin
      set_in(1'b1, 32'hE00 + i, 0, (i == 64), 8'(i));
      tick();
      if (valid_o) begin
        if (prev_s == 6'd63 && s_o == 6'd0 && data_o == 32'hE40) saw = 1'b1;
        prev_s = s_o;
      end
    end
    wait_empty(ok);
    tests++;
    if (!ok || !saw || SSI_o !== 4'd8 || s_o !== 6'd0) begin
      fails++;
      $display("FAIL wrap_s: empty=%b saw63to0=%b ssi=%0d s=%0d want 1 1 8 0", ok, saw, SSI_o, s_o);
    end
  endtask

  task automatic test_bad_block();
    b_ready_o  = 1'b1;
    b_in_valid = 1'b1;
    b_in_blk   = 2'd3;
    b_in_data  = 32'h99;
    b_in_last  = 1'b0;
    b_in_fdssi = 8'h01;
    tick();
    b_in_valid = 1'b0;
    tick();
    tests++;
    if (b_valid_o !== 1'b0 || b_err_o !== 1'b1 || b_FDSTI_o_all !== 3'b000 || b_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bad_discard: valid=%b err=%b fdsti=%b in_ready=%b want 0 1 000 1",
               b_valid_o, b_err_o, b_FDSTI_o_all, b_in_ready);
    end
    b_ready_o  = 1'b0;
    b_in_valid = 1'b1;
    b_in_blk   = 2'd1;
    b_in_data  = 32'h55;
    tick();
    b_in_valid = 1'b0;
    tests++;
    if (b_valid_o !== 1'b1 || b_data_o !== 32'h55 || b_FDSTI_o_all !== 3'b010 || b_err_o !== 1'b1) begin
      fails++;
      $display("FAIL bad_then_good: valid=%b data=%h fdsti=%b err=%b want 1 55 010 1",
               b_valid_o, b_data_o, b_FDSTI_o_all, b_err_o);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    ready_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'hF0 + i, 1, 1'b0, 8'(i));
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (valid_o !== 1'b1 || FDSTI_o_all !== 4'b0010) begin
      fails++;
      $display("FAIL ar_loaded: valid=%b fdsti=%b want 1 0010", valid_o, FDSTI_o_all);
    end
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({valid_o, in_ready, FDSTI_o_all, SSI_o, s_o, err_o, b_err_o, b_valid_o} !== 19'd0) begin
      fails++;
      $display("FAIL ar_immediate: valid=%b in_ready=%b fdsti=%b ssi=%0d s=%0d err=%b berr=%b bvalid=%b want all 0",
               valid_o, in_ready, FDSTI_o_all, SSI_o, s_o, err_o, b_err_o, b_valid_o);
    end
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL ar_release: in_ready=%b valid=%b want 1 0", in_ready, valid_o);
    end
    mon_en = 1'b1;
    ready_o = 1'b1;
    set_in(1'b1, 32'h1234, 0, 1'b1, 8'h7);
    tick();
    wait_empty(ok);
    tests++;
    if (!ok || SSI_o !== 4'd1 || s_o !== 6'd0) begin
      fails++;
      $display("FAIL ar_restart: empty=%b ssi=%0d s=%0d want 1 1 0", ok, SSI_o, s_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    b_in_valid = 1'b0;
    b_in_data  = 32'd0;
    b_in_blk   = 2'd0;
    b_in_last  = 1'b0;
    b_in_fdssi = 8'd0;
    b_ready_o  = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_concurrent();
    test_wrap();
    test_bad_block();
    test_async_reset();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d entries never emitted", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dom_conv_src.md
Name: dom_conv_src

Overview:
- Source side of the domain-conversion output interface: the transmitter that generates valid_o, wt_o, FDSSI_o, FDSTI_o_all, SSI_o, s_o and data_o, and obeys ready_o, for the dom_conv receiver.
- Accepts tagged samples from the upstream datapath and buffers them in a shared FIFO.
- Emits them in order with a valid/ready handshake, per-frame sequencing and sample offsets.
- Publishes a per-block pending-status vector.

Parameters:
- I_DATA_WIDTH, 32, sample data width.
- I_FDSSI_WIDTH, 8, frame-descriptor sample index width (passed through from input).
- I_SSI_WIDTH, 4, stream sequence index (frame counter) width.
- I_SAM_OFFSET, 6, sample-offset-within-frame counter width.
- FIFO_NUM_O_BLK, 4, number of output blocks tracked in FDSTI_o_all.
- FIFO_DEPTH, 8, shared FIFO entries; power of two, at least 2.
- BLK_W, max(1,$clog2(FIFO_NUM_O_BLK)), derived width of in_blk.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  FIFO can accept.
- in_data  in  I_DATA_WIDTH  sample payload.
- in_blk  in  BLK_W  destination block index.
- in_last  in  1  last sample of frame.
- in_fdssi  in  I_FDSSI_WIDTH  descriptor sample index.
- valid_o  out  1  output sample valid.
- ready_o  in  1  downstream accepts.
- data_o  out  I_DATA_WIDTH  head payload.
- wt_o  out  1  head is last sample of frame.
- FDSSI_o  out  I_FDSSI_WIDTH  head descriptor index.
- SSI_o  out  I_SSI_WIDTH  current frame sequence number.
- s_o  out  I_SAM_OFFSET  offset of head sample within current frame.
- FDSTI_o_all  out  FIFO_NUM_O_BLK  bit b = block b has ≥1 entry in FIFO.
- err_o  out  1  sticky: out-of-range in_blk seen.

Behaviour:
- Reset (async assert, sync release): FIFO empty, all pointers/counters 0. Outputs: valid_o=0, in_ready=0 during reset then 1, data_o/wt_o/FDSSI_o/SSI_o/s_o/FDSTI_o_all/err_o = 0.
- Push: in_valid && in_ready. in_ready = !full; it does not depend on same-cycle pop.
- Pop: valid_o && ready_o.
- FIFO entry = {data, blk, last, fdssi}.
- Push to empty FIFO: valid_o=1 the next cycle; latency 1, no bypass.
- valid_o = !empty. data_o/wt_o/FDSSI_o come from the FIFO head.
- While valid_o=1 and ready_o=0, all outputs hold stable.
- Simultaneous push and pop: allowed when not full and not empty; occupancy unchanged.
- s_o: 0 after reset. +1 on each pop with wt_o=0. Cleared to 0 on a pop with wt_o=1. Wraps modulo 2^I_SAM_OFFSET without flagging.
- SSI_o: +1 on each pop with wt_o=1, wraps modulo 2^I_SSI_WIDTH.
- Per-block counters (width $clog2(FIFO_DEPTH+1)):
  - Push of block b increments counter b.
  - Pop of a head with block b decrements counter b.
  - Push and pop of the same block in one cycle: no change.
  - FDSTI_o_all[b] = (counter b != 0), registered together with the counters.
- in_blk ≥ FIFO_NUM_O_BLK: handshake completes (in_ready honoured), entry discarded, not written, err_o set. err_o clears only on rst.
- Full: in_ready=0. A pop in that cycle frees space; in_ready rises the next cycle.
- Reset mid-operation: all buffered entries are discarded, counters and status clear immediately (async), and SSI_o/s_o restart at 0.

Test Plan:
- Reset then idle:
  - Apply rst, hold in_valid=0.
  - Required: valid_o=0, SSI_o=0, s_o=0, FDSTI_o_all=4'b0000, in_ready=1 the cycle after release.
- Single frame:
  - Push 3 samples, data 0xA0,0xA1,0xA2, blk 2, last on 3rd; ready_o=1.
  - Required: valid_o rises 1 cycle after the first push.
  - Outputs in order with s_o=0,1,2 and wt_o on 0xA2.
  - Then SSI_o=1 and s_o=0; FDSTI_o_all[2] is 1 while pending, 0 after the drain.
- Backpressure/full:
  - ready_o=0, push 10 samples.
  - Required: in_ready drops after 8 accepted; outputs held stable on head 0.
  - Raise ready_o for 1 cycle: in_ready=1 the next cycle, and the next head appears.
- Concurrent push/pop:
  - Steady stream with in_valid=ready_o=1, alternating blk 0/1.
  - Required: occupancy constant, FDSTI_o_all stable at 2'b11 in the low bits, no lost or reordered data.
- Wrap:
  - Send 16 frames of 1 sample each with wt_o=1.
  - Required: SSI_o goes 15→0.
  - Then send a 65-sample frame: s_o wraps 63→0 at sample 65.
- Bad block and async reset:
  - With FIFO_NUM_O_BLK=3, push blk=3.
  - Required: no entry written, err_o=1.
  - Assert rst mid-stream: valid_o=0 and err_o=0 immediately.
